// File: rtl/calc_pkg.sv
// Shared op codes, display selectors and FSM state encoding for the calculator controller.
package calc_pkg;

  localparam logic [1:0] OpAdd = 2'd0;
  localparam logic [1:0] OpSub = 2'd1;
  localparam logic [1:0] OpMul = 2'd2;
  localparam logic [1:0] OpDiv = 2'd3;

  localparam logic [1:0] DispA   = 2'd0;
  localparam logic [1:0] DispB   = 2'd1;
  localparam logic [1:0] DispRes = 2'd2;
  localparam logic [1:0] DispErr = 2'd3;

  localparam logic [15:0] ErrDispVal = 16'hEEEE;

  localparam int unsigned BtnLoadA = 0;
  localparam int unsigned BtnLoadB = 1;
  localparam int unsigned BtnNextOp = 2;
  localparam int unsigned BtnExec = 3;

  typedef enum logic [2:0] {
    StIdle,
    StASet,
    StBSet,
    StExec,
    StShow,
    StErr
  } state_e;

endpackage

// File: rtl/btn_edge.sv
// Multi-bit button synchroniser (SYNC_STAGES flops per bit) followed by a rising-edge pulser.
module btn_edge #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_rise
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]                  r_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  // Combinational pulse so the FSM acts SYNC_STAGES+1 edges after the raw change.
  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/calc_seq_ctrl.sv
// MiniCalculator sequencing controller: buttons -> operand/op/execute, ALU handshake, display.
// Optional macro CALC_SEQ_CTRL_CHAIN_EN: btn1 in SHOW chains the result into A.
module calc_seq_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned OPW         = 8,
  parameter int unsigned RESW        = 16,
  parameter int unsigned TIMEOUT     = 64,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      btn_i,
  input  logic [OPW-1:0]  sw_i,
  output logic            alu_start_o,
  output logic [1:0]      alu_op_o,
  output logic [OPW-1:0]  alu_a_o,
  output logic [OPW-1:0]  alu_b_o,
  input  logic            alu_done_i,
  input  logic [RESW-1:0] alu_res_i,
  output logic [RESW-1:0] disp_val_o,
  output logic [1:0]      disp_sel_o,
  output logic            busy_o,
  output logic            led_o
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  logic [3:0]      w_rise;
  logic [3:0]      w_act;
  logic            w_exec_ok;
  state_e          r_state;
  logic [OPW-1:0]  r_a;
  logic [OPW-1:0]  r_b;
  logic [1:0]      r_op;
  logic [RESW-1:0] r_res;
  logic            r_start;
  logic [CntW-1:0] r_cnt;
  logic [RESW-1:0] r_disp_val;
  logic [1:0]      r_disp_sel;

  btn_edge #(
    .WIDTH      (4),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_btn_edge (
    .clk   (clk),
    .rst   (rst),
    .i_raw (btn_i),
    .o_rise(w_rise)
  );

  // Only the highest-priority simultaneous edge survives; the rest are dropped.
  always_comb begin
    w_act = '0;
    if (w_rise[BtnExec])        w_act[BtnExec]   = 1'b1;
    else if (w_rise[BtnNextOp]) w_act[BtnNextOp] = 1'b1;
    else if (w_rise[BtnLoadB])  w_act[BtnLoadB]  = 1'b1;
    else if (w_rise[BtnLoadA])  w_act[BtnLoadA]  = 1'b1;
  end

  assign w_exec_ok = !((r_op == OpDiv) && (r_b == '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= OpAdd;
      r_res   <= '0;
      r_start <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_start <= 1'b0;
      if (w_act[BtnNextOp] && (r_state != StExec)) r_op <= r_op + 2'd1;
      unique case (r_state)
        StIdle: begin
          if (w_act[BtnLoadA]) begin
            r_a     <= sw_i;
            r_state <= StASet;
          end
        end
        StASet: begin
          if (w_act[BtnLoadA]) begin
            r_a <= sw_i;
          end else if (w_act[BtnLoadB]) begin
            r_b     <= sw_i;
            r_state <= StBSet;
          end
        end
        StBSet: begin
          if (w_act[BtnLoadB]) begin
            r_b <= sw_i;
          end else if (w_act[BtnExec]) begin
            if (w_exec_ok) begin
              r_state <= StExec;
              r_start <= 1'b1;
              r_cnt   <= '0;
            end else begin
              r_state <= StErr;
            end
          end
        end
        StExec: begin
          if (alu_done_i) begin
            r_res   <= alu_res_i;
            r_state <= StShow;
          end else if (r_cnt == CntLast) begin
            r_state <= StErr;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StShow: begin
          if (w_act[BtnLoadA]) begin
            r_a     <= sw_i;
            r_state <= StASet;
          end else if (w_act[BtnExec]) begin
            if (w_exec_ok) begin
              r_state <= StExec;
              r_start <= 1'b1;
              r_cnt   <= '0;
            end else begin
              r_state <= StErr;
            end
          end
`ifdef CALC_SEQ_CTRL_CHAIN_EN
          else if (w_act[BtnLoadB]) begin
            r_a     <= r_res[OPW-1:0];
            r_b     <= sw_i;
            r_state <= StBSet;
          end
`endif
        end
        StErr: begin
          if (w_act[BtnLoadA]) begin
            r_a     <= sw_i;
            r_state <= StASet;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Display trails the state/register update by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_disp_sel <= DispA;
      r_disp_val <= '0;
    end else begin
      unique case (r_state)
        StIdle, StASet: begin
          r_disp_sel <= DispA;
          r_disp_val <= RESW'(r_a);
        end
        StBSet: begin
          r_disp_sel <= DispB;
          r_disp_val <= RESW'(r_b);
        end
        StExec, StShow: begin
          r_disp_sel <= DispRes;
          r_disp_val <= r_res;
        end
        StErr: begin
          r_disp_sel <= DispErr;
          r_disp_val <= RESW'(ErrDispVal);
        end
        default: begin
          r_disp_sel <= DispA;
          r_disp_val <= '0;
        end
      endcase
    end
  end

  assign alu_start_o = r_start;
  assign alu_op_o    = r_op;
  assign alu_a_o     = r_a;
  assign alu_b_o     = r_b;
  assign disp_val_o  = r_disp_val;
  assign disp_sel_o  = r_disp_sel;
  assign busy_o      = (r_state == StExec);
  assign led_o       = (r_state == StErr);

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Scoreboard bench for calc_seq_ctrl: a behavioural model queues expected start/display events.
module tb_calc_seq_ctrl;

  localparam int unsigned OPW = 8;
  localparam int unsigned RESW = 16;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned SYNC_STAGES = 2;

  localparam int MIdle = 0, MASet = 1, MBSet = 2, MExec = 3, MShow = 4, MErr = 5;

  typedef struct {
    bit          is_start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [1:0]  op;
    logic [1:0]  sel;
    logic [15:0] val;
    bit          led;
    bit          busy;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [3:0]  btn_i;
  logic [7:0]  sw_i;
  logic        alu_start_o;
  logic [1:0]  alu_op_o;
  logic [7:0]  alu_a_o;
  logic [7:0]  alu_b_o;
  logic        alu_done_i;
  logic [15:0] alu_res_i;
  logic [15:0] disp_val_o;
  logic [1:0]  disp_sel_o;
  logic        busy_o;
  logic        led_o;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   late_cnt = 0;
  bit   tmo_mode = 0;
  bit   mon_en = 0;
  exp_t exp_q[$];

  int          m_st;
  logic [7:0]  m_a, m_b;
  int          m_op;
  logic [15:0] m_res;
  logic [1:0]  m_sel;
  logic [15:0] m_val;

  calc_seq_ctrl #(
    .OPW        (OPW),
    .RESW       (RESW),
    .TIMEOUT    (TIMEOUT),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_i      (btn_i),
    .sw_i       (sw_i),
    .alu_start_o(alu_start_o),
    .alu_op_o   (alu_op_o),
    .alu_a_o    (alu_a_o),
    .alu_b_o    (alu_b_o),
    .alu_done_i (alu_done_i),
    .alu_res_i  (alu_res_i),
    .disp_val_o (disp_val_o),
    .disp_sel_o (disp_sel_o),
    .busy_o     (busy_o),
    .led_o      (led_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input int op);
    case (op)
      0:       return 16'(a) + 16'(b);
      1:       return 16'(a) - 16'(b);
      2:       return 16'(a) * 16'(b);
      default: return (b == 8'h00) ? 16'hFFFF : 16'(a) / 16'(b);
    endcase
  endfunction

  // ---------------- reference model ----------------
  task automatic m_reset();
    m_st = MIdle; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_sel = 0; m_val = 0;
  endtask

  task automatic m_note();
    logic [1:0] s;
    logic [15:0] v;
    exp_t e;
    case (m_st)
      MIdle, MASet: begin s = 2'd0; v = {8'h00, m_a}; end
      MBSet:        begin s = 2'd1; v = {8'h00, m_b}; end
      MExec, MShow: begin s = 2'd2; v = m_res; end
      default:      begin s = 2'd3; v = 16'hEEEE; end
    endcase
    if (s != m_sel || v != m_val) begin
      e.is_start = 0; e.a = 0; e.b = 0; e.op = 0;
      e.sel = s; e.val = v; e.led = (m_st == MErr); e.busy = (m_st == MExec);
      exp_q.push_back(e);
      m_sel = s;
      m_val = v;
    end
  endtask

  task automatic m_exec();
    exp_t e;
    if (m_op == 3 && m_b == 0) begin
      m_st = MErr;
      m_note();
    end else begin
      e.is_start = 1; e.a = m_a; e.b = m_b; e.op = 2'(m_op);
      e.sel = 0; e.val = 0; e.led = 0; e.busy = 1;
      exp_q.push_back(e);
      m_st = MExec;
      m_note();
      if (tmo_mode) begin
        m_st = MErr;
      end else begin
        m_res = alu_fn(m_a, m_b, m_op);
        m_st = MShow;
      end
      m_note();
    end
  endtask

  task automatic m_act(input logic [3:0] mask, input logic [7:0] sw);
    int k;
    k = -1;
    for (int i = 3; i >= 0; i--) if (mask[i] && k < 0) k = i;
    if (k == 2) begin
      if (m_st != MExec) m_op = (m_op + 1) % 4;
    end else begin
      case (m_st)
        MIdle: if (k == 0) begin m_a = sw; m_st = MASet; end
        MASet: begin
          if (k == 0) m_a = sw;
          else if (k == 1) begin m_b = sw; m_st = MBSet; end
        end
        MBSet: begin
          if (k == 1) m_b = sw;
          else if (k == 3) m_exec();
        end
        MShow: begin
          if (k == 0) begin m_a = sw; m_st = MASet; end
          else if (k == 3) m_exec();
`ifdef CALC_SEQ_CTRL_CHAIN_EN
          else if (k == 1) begin m_a = m_res[7:0]; m_b = sw; m_st = MBSet; end
`endif
        end
        MErr: if (k == 0) begin m_a = sw; m_st = MASet; end
        default: ;
      endcase
    end
    m_note();
  endtask

  // ---------------- ALU responder ----------------
  initial begin : alu_resp
    int unsigned dly;
    bit pend;
    logic [15:0] r;
    int late_seen;
    alu_done_i = 1'b0; alu_res_i = 16'h0; pend = 0; dly = 0; r = 0; late_seen = 0;
    forever begin
      @(negedge clk);
      alu_done_i = 1'b0;
      if (!rst) begin
        pend = 0;
      end else if (late_cnt != late_seen) begin
        late_seen = late_cnt;
        alu_done_i = 1'b1;
        alu_res_i = 16'h1234;
      end else if (pend) begin
        if (dly == 0) begin
          alu_done_i = 1'b1;
          alu_res_i = r;
          pend = 0;
        end else begin
          dly--;
        end
      end else if (alu_start_o && !tmo_mode) begin
        pend = 1;
        dly = $urandom_range(0, 8);
        r = alu_fn(alu_a_o, alu_b_o, int'(alu_op_o));
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [1:0] p_sel;
    logic [15:0] p_val;
    bit p_led, p_busy;
    int t_start;
    exp_t e;
    p_sel = 0; p_val = 0; p_led = 0; p_busy = 0; t_start = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (alu_start_o) begin
          t_start = cyc;
          if (exp_q.size() == 0) begin
            chk("unexpected start pulse", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("event kind at start", 1, e.is_start);
            if (e.is_start) begin
              chk("start a", alu_a_o, e.a);
              chk("start b", alu_b_o, e.b);
              chk("start op", alu_op_o, e.op);
              chk("start busy", busy_o, e.busy);
            end
          end
        end
        if (disp_sel_o !== p_sel || disp_val_o !== p_val) begin
          if (exp_q.size() == 0) begin
            chk("unexpected display change", {14'h0, disp_sel_o, disp_val_o}, {14'h0, p_sel, p_val});
          end else begin
            e = exp_q.pop_front();
            chk("event kind at display", 0, e.is_start);
            if (!e.is_start) begin
              chk("disp sel", disp_sel_o, e.sel);
              chk("disp val", disp_val_o, e.val);
              chk("led", led_o, e.led);
              chk("busy", busy_o, e.busy);
            end
          end
        end
        if (led_o && !p_led && p_busy) chk("timeout latency", cyc - t_start, TIMEOUT);
      end
      p_sel = disp_sel_o; p_val = disp_val_o; p_led = led_o; p_busy = busy_o;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_quiet();
    int n;
    repeat (8) @(negedge clk);
    n = 0;
    while (busy_o && n < int'(TIMEOUT) + 20) begin
      @(negedge clk);
      n++;
    end
    if (busy_o) chk("exec did not end", 1, 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] mask, input logic [7:0] sw, input int hold);
    @(negedge clk);
    sw_i = sw;
    btn_i = mask;
    m_act(mask, sw);
    repeat (hold) @(negedge clk);
    btn_i = 4'h0;
    wait_quiet();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " start"}, alu_start_o, 0);
    chk({tag, " op"}, alu_op_o, 0);
    chk({tag, " a"}, alu_a_o, 0);
    chk({tag, " b"}, alu_b_o, 0);
    chk({tag, " disp val"}, disp_val_o, 0);
    chk({tag, " disp sel"}, disp_sel_o, 0);
    chk({tag, " busy"}, busy_o, 0);
    chk({tag, " led"}, led_o, 0);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin : stim
    logic [3:0] mask;
    rst = 1'b0; btn_i = 4'h0; sw_i = 8'h00;
    m_reset();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;
    mon_en = 1;

    // Add
    press(4'b0001, 8'h22, 2);
    press(4'b0010, 8'h05, 2);
    press(4'b1000, 8'h00, 2);
    // Divide by zero
    repeat (3) press(4'b0100, 8'h00, 1);
    press(4'b0001, 8'h10, 2);
    press(4'b0010, 8'h00, 2);
    press(4'b1000, 8'h00, 2);
    press(4'b0001, 8'h01, 2);
    // Timeout with a late done afterwards
    press(4'b0010, 8'h07, 2);
    tmo_mode = 1;
    press(4'b1000, 8'h00, 2);
    late_cnt++;
    repeat (6) @(negedge clk);
    tmo_mode = 0;
    // Priority and held button
    press(4'b0001, 8'h30, 2);
    press(4'b0010, 8'h04, 2);
    press(4'b1001, 8'h55, 2);
    @(negedge clk);
    sw_i = 8'h66;
    btn_i = 4'b0001;
    m_act(4'b0001, 8'h66);
    repeat (10) @(negedge clk);
    sw_i = 8'h77;
    repeat (90) @(negedge clk);
    btn_i = 4'h0;
    wait_quiet();
    // Reset during EXEC
    press(4'b0010, 8'h09, 2);
    tmo_mode = 1;
    @(negedge clk);
    btn_i = 4'b1000;
    m_act(4'b1000, 8'h09);
    repeat (2) @(negedge clk);
    btn_i = 4'h0;
    repeat (12) @(negedge clk);
    chk("busy before reset", busy_o, 1);
    mon_en = 0;
    rst = 1'b0;
    #1;
    chk_all_zero("mid-exec reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    m_reset();
    tmo_mode = 0;
    mon_en = 1;
    repeat (20) @(negedge clk);
    // Op wrap, then chaining from SHOW
    repeat (5) press(4'b0100, 8'h00, 1);
    press(4'b0001, 8'h50, 2);
    press(4'b0010, 8'h20, 2);
    press(4'b1000, 8'h00, 2);
    press(4'b0100, 8'h00, 1);
    press(4'b0001, 8'h20, 2);
    press(4'b0010, 8'h0A, 2);
    press(4'b1000, 8'h00, 2);
    press(4'b0010, 8'h03, 2);
    press(4'b1000, 8'h00, 2);
    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 4) == 0) mask = 4'($urandom_range(1, 15));
      else mask = 4'b0001 << $urandom_range(0, 3);
      tmo_mode = ($urandom_range(0, 19) == 0);
      press(mask, 8'($urandom), int'($urandom_range(1, 5)));
    end
    tmo_mode = 0;
    repeat (10) @(negedge clk);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_seq_ctrl.md
Name: calc_seq_ctrl

Overview:
- Sequencing controller for the MiniCalculator datapath.
- Turns raw button/switch input into operand loads, operator selection and execute requests.
- Drives a multi-cycle ALU through a start/done handshake and chooses what `top` shows on the 7-segment driver and LED.
- Sits between the board I/O (`btn_i`, `sw_i`) and the ALU/display blocks inside `top`.

Parameters:
- OPW, 8: operand width (equals `sw_i` width).
- RESW, 16: ALU result and display value width.
- TIMEOUT, 64: cycles allowed between `alu_start_o` and `alu_done_i` before the error state.
- SYNC_STAGES, 2: synchroniser flops per button bit (minimum 2).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- btn_i  input  4  raw buttons: [0] load A, [1] load B, [2] next op, [3] execute.
- sw_i  input  OPW  operand value switches.
- alu_start_o  output  1  one-cycle start pulse to the ALU.
- alu_op_o  output  2  operator: 0 add, 1 sub, 2 mul, 3 div.
- alu_a_o  output  OPW  operand A.
- alu_b_o  output  OPW  operand B.
- alu_done_i  input  1  ALU result valid, one-cycle pulse.
- alu_res_i  input  RESW  ALU result, sampled when `alu_done_i` is 1.
- disp_val_o  output  RESW  value to display.
- disp_sel_o  output  2  display source: 0 A, 1 B, 2 result, 3 error.
- busy_o  output  1  high while in EXEC.
- led_o  output  1  error indicator.

Behaviour:
- **Reset** (`rst`=0, asynchronous): state IDLE; A, B, op and result registers cleared to 0. Outputs: `alu_start_o`=0, `alu_op_o`=0, `alu_a_o`=0, `alu_b_o`=0, `disp_val_o`=0, `disp_sel_o`=0, `busy_o`=0, `led_o`=0. Reset mid-EXEC aborts with no start re-issued. Synchronisers are cleared.
- **Buttons:**
  - Each bit passes through SYNC_STAGES flops, then a rising-edge detector.
  - An action fires SYNC_STAGES+1 cycles after the raw edge.
  - A held button produces one action only.
  - If several edges arrive in the same cycle, only the highest priority is taken: btn3 > btn2 > btn1 > btn0. The rest are dropped.
- **FSM states:** IDLE, A_SET, B_SET, EXEC, SHOW, ERR.
  - IDLE: btn0 latches A = `sw_i` and moves to A_SET. btn1 and btn3 are ignored.
  - A_SET: btn0 reloads A. btn1 latches B = `sw_i` and moves to B_SET. btn3 is ignored.
  - B_SET: btn1 reloads B. btn3 executes:
    - if op==3 and B==0, go to ERR without starting the ALU;
    - otherwise go to EXEC and pulse `alu_start_o` for one cycle, in the cycle after the action.
  - EXEC: `busy_o`=1. `alu_a_o`, `alu_b_o` and `alu_op_o` stay stable until exit. All buttons are ignored. The timeout counter starts at 0 on the start cycle.
    - `alu_done_i`=1: latch `alu_res_i` and go to SHOW.
    - Counter reaches TIMEOUT-1 without done: go to ERR.
    - If done and timeout occur in the same cycle, done wins.
  - SHOW: btn0 loads A and moves to A_SET. btn3 re-executes with the same A/B/op, including the div-by-zero check.
  - ERR: `led_o`=1. btn0 loads A and moves to A_SET, clearing `led_o`. All other buttons are ignored.
- **btn2** in IDLE, A_SET, B_SET, SHOW or ERR: op = op+1 mod 4 (3 wraps to 0). The state is unchanged. btn2 in EXEC is ignored.
- **`alu_done_i`** outside EXEC is ignored.
- **Display** (registered, one cycle after the state/register update):
  - IDLE and A_SET: sel 0, value = zero-extended A.
  - B_SET: sel 1, value = zero-extended B.
  - EXEC and SHOW: sel 2, value = result register (previous result held during EXEC).
  - ERR: sel 3, value = 16'hEEEE.
- **Arithmetic:** the controller does none. Operands are unsigned OPW-bit values; result interpretation is up to the ALU.

Optional Feature:
- **With CALC_SEQ_CTRL_CHAIN_EN defined:** btn1 in SHOW sets A = result[OPW-1:0] and B = `sw_i`, then moves to B_SET. This chains calculations.
- **Without it:** btn1 in SHOW is ignored.

Decomposition:
- Package `calc_pkg` holds:
  - the op code constants (ADD/SUB/MUL/DIV);
  - the FSM state enum;
  - the `disp_sel` codes;
  - the ERR display constant 16'hEEEE.
- One sub-module, `btn_edge`: parameterised width and SYNC_STAGES synchroniser plus rising-edge pulse generator. It is instantiated once for all 4 bits.

Test Plan:
1. **Add:** `sw_i`=0x22, btn0 → A=0x22, sel 0; `sw_i`=0x05, btn1 → sel 1 value 0x0005; btn3 → single `alu_start_o` with a=0x22, b=0x05, op=0; done with res 0x0027 → SHOW, `disp_val_o`=0x0027.
2. **Div by zero:** btn2 pressed 3 times (op=3), A=0x10, B=0x00, btn3 → no `alu_start_o`, ERR, `led_o`=1, `disp_val_o`=0xEEEE; btn0 with `sw_i`=0x01 → A_SET, `led_o`=0.
3. **Timeout:** execute with `alu_done_i` held 0 → ERR entered exactly TIMEOUT cycles after start; a late `alu_done_i` pulse is ignored.
4. **Priority and hold:** btn3 and btn0 rise in the same cycle in B_SET → execute only, A unchanged; btn0 held high for 100 cycles → one load only.
5. **Reset mid-EXEC:** `rst` low 2 cycles during EXEC → all outputs 0, IDLE; no start pulse after release.
6. **Op wrap and chain:** btn2 ×5 from reset → op=1. With CALC_SEQ_CTRL_CHAIN_EN, SHOW result 0x0140 then btn1 with `sw_i`=0x03 → a=0x40, b=0x03, B_SET.
